// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared pipeline types and constants for the hazard controller
package hazard_ctrl_pkg;

   localparam int REG_W    = 3;
   localparam int SB_DEPTH = 2;
   localparam int CNT_W    = 16;

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_STALL = 2'b01,
      ST_HALT  = 2'b10
   } hz_state_e;

   typedef struct packed {
      logic             vld;
      logic [REG_W-1:0] rnum;
   } sb_entry_t;

   localparam int SB_ENTRY_W = $bits(sb_entry_t);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - decode/execute hazard bundle between pipeline and hazard controller
interface hazard_ctrl_if;
   import hazard_ctrl_pkg::*;

   logic             srcAValidD;
   logic [REG_W-1:0] srcAD;
   logic             srcBValidD;
   logic [REG_W-1:0] srcBD;
   logic             regWrtD;
   logic [REG_W-1:0] wrtRegD;
   logic             haltD;
   logic             brchTakenX;
   logic             stallF;
   logic             stallD;
   logic             bubbleX;
   logic             flushD;
   logic             halted;
   logic [CNT_W-1:0] stallCnt;

   modport master (
      output srcAValidD, srcAD, srcBValidD, srcBD, regWrtD, wrtRegD, haltD, brchTakenX,
      input  stallF, stallD, bubbleX, flushD, halted, stallCnt
   );

   modport slave (
      input  srcAValidD, srcAD, srcBValidD, srcBD, regWrtD, wrtRegD, haltD, brchTakenX,
      output stallF, stallD, bubbleX, flushD, halted, stallCnt
   );

endinterface

// File: rtl/dff.sv
// rtl/dff.sv - team flop cell: W-bit register, asynchronous active-high reset to RST_VAL
module dff #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] q_q;

   // capture next value every edge, reset immediately on rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) q_q <= RST_VAL;
      else     q_q <= d_i;
   end

   assign q_o = q_q;

endmodule

// File: rtl/hazard_ctrl_sb_entry.sv
// rtl/hazard_ctrl_sb_entry.sv - one scoreboard entry {valid, reg} with bubble clear and source compare
module hz_sb_entry
   import hazard_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  sb_entry_t        ent_i,
   input  logic [REG_W-1:0] src_a_i,
   input  logic [REG_W-1:0] src_b_i,
   output sb_entry_t        ent_o,
   output logic             match_a_o,
   output logic             match_b_o
);

   sb_entry_t             ent_d;
   logic [SB_ENTRY_W-1:0] ent_q;

   // a bubble loads an invalid entry instead of the incoming instruction
   always_comb begin
      ent_d = ent_i;
      if (clr_i) ent_d = '0;
   end

   dff #(.W(SB_ENTRY_W)) u_ent_q (
      .clk (clk),
      .rst (rst),
      .d_i (ent_d),
      .q_o (ent_q)
   );

   assign ent_o     = sb_entry_t'(ent_q);
   assign match_a_o = ent_o.vld && (ent_o.rnum == src_a_i);
   assign match_b_o = ent_o.vld && (ent_o.rnum == src_b_i);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - in-order pipeline hazard controller: RAW stall, branch flush, HALT freeze
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   hazard_ctrl_if.slave   hz
);

   hz_state_e        state_d;
   logic [1:0]       state_q;
   logic             hazard;
   logic             stall_f;
   logic             stall_d;
   logic             bubble_x;
   logic             flush_d;
   logic             halted;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_q;

   sb_entry_t          ent_d   [SB_DEPTH];
   sb_entry_t          ent_q   [SB_DEPTH];
   logic [SB_DEPTH-1:0] clr;
   logic [SB_DEPTH-1:0] match_a;
   logic [SB_DEPTH-1:0] match_b;

   // entry 0 is the X stage, entry i+1 receives entry i (X -> M)
   for (genvar i = 0; i < SB_DEPTH; i++) begin : g_sb
      if (i == 0) begin : g_x
         assign ent_d[i] = '{vld: hz.regWrtD, rnum: hz.wrtRegD};
         assign clr[i]   = bubble_x;
      end else begin : g_older
         assign ent_d[i] = ent_q[i-1];
         assign clr[i]   = 1'b0;
      end

      hz_sb_entry u_ent (
         .clk       (clk),
         .rst       (rst),
         .clr_i     (clr[i]),
         .ent_i     (ent_d[i]),
         .src_a_i   (hz.srcAD),
         .src_b_i   (hz.srcBD),
         .ent_o     (ent_q[i]),
         .match_a_o (match_a[i]),
         .match_b_o (match_b[i])
      );
   end

   // RAW hazard: a read source matches any in-flight writer; R0 is not special
   assign hazard = (hz.srcAValidD && (|match_a)) || (hz.srcBValidD && (|match_b));

   dff #(.W(2), .RST_VAL(ST_RUN)) u_state_q (
      .clk (clk),
      .rst (rst),
      .d_i (state_d),
      .q_o (state_q)
   );

   // next state: HALT absorbs, then branch, then halt-without-hazard, then hazard
   always_comb begin
      state_d = ST_RUN;
      if (state_q == ST_HALT)          state_d = ST_HALT;
      else if (hz.brchTakenX)          state_d = ST_RUN;
      else if (hz.haltD && !hazard)    state_d = ST_HALT;
      else if (hazard)                 state_d = ST_STALL;
      else                             state_d = ST_RUN;
   end

   // pipeline controls, same cycle as the inputs; wrong-path flush beats any stall
   always_comb begin
      stall_f  = 1'b0;
      stall_d  = 1'b0;
      bubble_x = 1'b0;
      flush_d  = 1'b0;
      halted   = 1'b0;
      if (state_q == ST_HALT) begin
         stall_f  = 1'b1;
         stall_d  = 1'b1;
         bubble_x = 1'b1;
         halted   = 1'b1;
      end else if (hz.brchTakenX) begin
         flush_d  = 1'b1;
         bubble_x = 1'b1;
      end else if (hazard) begin
         stall_f  = 1'b1;
         stall_d  = 1'b1;
         bubble_x = 1'b1;
      end
   end

   // stall cycles counted outside HALT, saturating
   always_comb begin
      cnt_d = cnt_q;
      if (stall_d && (state_q != ST_HALT)) cnt_d = sat_inc(cnt_q);
   end

   dff #(.W(CNT_W)) u_cnt_q (
      .clk (clk),
      .rst (rst),
      .d_i (cnt_d),
      .q_o (cnt_q)
   );

   assign hz.stallF   = stall_f;
   assign hz.stallD   = stall_d;
   assign hz.bubbleX  = bubble_x;
   assign hz.flushD   = flush_d;
   assign hz.halted   = halted;
   assign hz.stallCnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   hazard_ctrl_if hz_if ();

   hazard_ctrl u_dut (
      .clk (clk),
      .rst (rst),
      .hz  (hz_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // {stallF, stallD, bubbleX, flushD, halted}
   task automatic chk_out(input string tag, input logic [4:0] exp);
      chk(tag, 16'({hz_if.stallF, hz_if.stallD, hz_if.bubbleX, hz_if.flushD, hz_if.halted}),
          16'(exp));
   endtask

   task automatic chk_cnt(input string tag, input logic [15:0] exp);
      chk(tag, hz_if.stallCnt, exp);
   endtask

   task automatic drive(input logic av, input logic [2:0] a, input logic bv, input logic [2:0] b,
                        input logic rw, input logic [2:0] wr, input logic hd, input logic bt);
      hz_if.srcAValidD = av;
      hz_if.srcAD      = a;
      hz_if.srcBValidD = bv;
      hz_if.srcBD      = b;
      hz_if.regWrtD    = rw;
      hz_if.wrtRegD    = wr;
      hz_if.haltD      = hd;
      hz_if.brchTakenX = bt;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   localparam logic [4:0] O_IDLE  = 5'b00000;
   localparam logic [4:0] O_STALL = 5'b11100;
   localparam logic [4:0] O_FLUSH = 5'b00110;
   localparam logic [4:0] O_HALT  = 5'b11101;

   initial begin
      n_chk = 0;
      n_err = 0;
      rst   = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      chk_out("rst_outs", O_IDLE);
      chk_cnt("rst_cnt", 16'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // dependency on X: two stall cycles
      drive(0, 0, 0, 0, 1, 3, 0, 0);
      chk_out("x_writer", O_IDLE);
      step();
      drive(1, 3, 0, 0, 0, 0, 0, 0);
      chk_out("x_stall1", O_STALL);
      step();
      chk_out("x_stall2", O_STALL);
      step();
      chk_out("x_release", O_IDLE);
      chk_cnt("x_cnt", 16'd2);
      step();

      // dependency on M via srcB: one stall cycle
      drive(0, 0, 0, 0, 1, 5, 0, 0);
      step();
      drive(0, 0, 0, 0, 1, 1, 0, 0);
      chk_out("m_indep", O_IDLE);
      step();
      drive(0, 0, 1, 5, 0, 0, 0, 0);
      chk_out("m_stall", O_STALL);
      step();
      chk_out("m_release", O_IDLE);
      chk_cnt("m_cnt", 16'd3);
      step();

      // R0 is an ordinary register
      drive(0, 0, 0, 0, 1, 0, 0, 0);
      step();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      chk_out("r0_stall1", O_STALL);
      step();
      chk_out("r0_stall2", O_STALL);
      step();
      chk_out("r0_release", O_IDLE);
      chk_cnt("r0_cnt", 16'd5);
      step();

      // source valid low means no hazard
      drive(0, 0, 0, 0, 1, 4, 0, 0);
      step();
      drive(0, 4, 0, 0, 0, 0, 0, 0);
      chk_out("novalid", O_IDLE);
      step();

      // branch overrides a simultaneous hazard; killed instr leaves sbX invalid
      drive(0, 0, 0, 0, 1, 2, 0, 0);
      step();
      drive(1, 2, 0, 0, 1, 6, 0, 1);
      chk_out("br_flush", O_FLUSH);
      step();
      drive(1, 6, 0, 0, 0, 0, 0, 0);
      chk_out("br_killed", O_IDLE);
      chk_cnt("br_cnt", 16'd5);
      step();

      // branch overrides haltD
      drive(0, 0, 0, 0, 0, 0, 1, 1);
      chk_out("br_halt_flush", O_FLUSH);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk_out("br_halt_run", O_IDLE);
      step();

      // haltD with a hazard stalls first, halts once the hazard clears
      drive(0, 0, 0, 0, 1, 7, 0, 0);
      step();
      drive(1, 7, 0, 0, 0, 0, 1, 0);
      chk_out("hz_halt_stall1", O_STALL);
      step();
      chk_out("hz_halt_stall2", O_STALL);
      step();
      chk_out("hz_halt_go", O_IDLE);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 100; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, (i % 7) == 3);
         chk_out($sformatf("halt_hold%0d", i), O_HALT);
         step();
      end
      chk_cnt("halt_cnt", 16'd7);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      #1;
      chk_out("halt_rst_outs", O_IDLE);
      chk_cnt("halt_rst_cnt", 16'd0);
      step();
      rst = 1'b0;
      #1;
      chk_out("halt_post_rst", O_IDLE);
      step();

      // plain haltD with no hazard: halted from next cycle
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      chk_out("halt_entry", O_IDLE);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk_out("halt_now", O_HALT);
      rst = 1'b1;
      #1;
      chk_out("halt2_rst", O_IDLE);
      step();
      rst = 1'b0;
      #1;

      // async reset between edges mid-stall
      drive(0, 0, 0, 0, 1, 3, 0, 0);
      step();
      drive(1, 3, 0, 0, 0, 0, 0, 0);
      step();
      chk_out("ar_stall", O_STALL);
      chk_cnt("ar_cnt_pre", 16'd1);
      #1;
      rst = 1'b1;
      #1;
      chk_out("ar_outs", O_IDLE);
      chk_cnt("ar_cnt", 16'd0);
      rst = 1'b0;
      #1;
      chk_out("ar_sb_empty", O_IDLE);
      step();
      chk_out("ar_run", O_IDLE);
      chk_cnt("ar_cnt_post", 16'd0);
      step();

      // saturation: self-dependent writer, 2 stalls per 3 cycles
      drive(1, 3, 0, 0, 1, 3, 0, 0);
      for (int i = 0; i < 32767; i++) begin
         step();
         step();
         step();
      end
      chk_cnt("sat_fffe", 16'hFFFE);
      for (int i = 0; i < 3; i++) begin
         step();
         step();
         step();
         chk_cnt($sformatf("sat_ffff%0d", i), 16'hFFFF);
      end
      chk_out("sat_still_stalling", O_IDLE);
      step();
      chk_out("sat_stall", O_STALL);
      chk_cnt("sat_hold", 16'hFFFF);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
